cond_unit: RTL
==============

// Module: cond_unit
// PURPOSE
//  Condition/flags unit for the single-cycle ARM core.
//  - Holds the NZCV status register.
//  - Updates it from the ALU flags under the 2-bit flag-write enables produced by the ALU decoder.
//  - Evaluates the instruction's 4-bit cond field against the stored flags.
//  - Gates the datapath write strobes (reg_write, mem_write, pc_src) so that non-executed
//    instructions have no architectural effect.
//  - Sits between the main/ALU decoders and the register file, data memory and PC mux.
// PARAMETERS
//  RESET_FLAGS  4'b0000  NZCV value loaded on reset, ordered {N,Z,C,V}
//  HAS_STALL    1        1: en input holds the flags and gates strobes; 0: en is ignored (treated as 1)
// PORTS
//  clk        in   1  core clock; flags update on rising edge
//  reset      in   1  asynchronous, active-high; clears flags to RESET_FLAGS
//  en         in   1  instruction-valid / not-stalled qualifier
//  cond       in   4  instr[31:28] condition field
//  alu_flags  in   4  {N,Z,C,V} from the ALU for the current instruction
//  flag_w     in   2  [1] write N,Z; [0] write C,V (from ALU decoder)
//  pcs        in   1  instruction writes PC (branch or write to R15)
//  reg_w      in   1  instruction writes the register file
//  mem_w      in   1  instruction writes data memory
//  no_write   in   1  suppress register write (CMP/TST)
//  pc_src     out  1  gated pcs
//  reg_write  out  1  gated reg_w & ~no_write
//  mem_write  out  1  gated mem_w
//  cond_ex    out  1  condition passed for the current instruction
//  flags      out  4  current stored {N,Z,C,V}
// BEHAVIOUR
//  - Flags register: asynchronous reset to RESET_FLAGS.
//    - On posedge clk with en & cond_ex:
//      - flag_w[1] loads N,Z from alu_flags[3:2].
//      - flag_w[0] loads C,V from alu_flags[1:0].
//    - Bits not enabled are held. flag_w=2'b11 updates all four in the same edge.
//  - cond_ex is combinational from cond and the STORED flags, never from alu_flags.
//  - Result latency: an instruction's flags become visible to the next instruction's
//    cond_ex one cycle later (zero bypass).
//  - Condition codes:
//    | cond | mnemonic | pass when        |
//    | 0000 | EQ       | Z               |
//    | 0001 | NE       | ~Z              |
//    | 0010 | CS       | C               |
//    | 0011 | CC       | ~C              |
//    | 0100 | MI       | N               |
//    | 0101 | PL       | ~N              |
//    | 0110 | VS       | V               |
//    | 0111 | VC       | ~V              |
//    | 1000 | HI       | C & ~Z          |
//    | 1001 | LS       | ~C \| Z         |
//    | 1010 | GE       | N == V          |
//    | 1011 | LT       | N != V          |
//    | 1100 | GT       | ~Z & (N == V)   |
//    | 1101 | LE       | Z \| (N != V)   |
//    | 1110 | AL       | 1               |
//    | 1111 | (unused) | 0 — never executes; no X propagation |
//  - Gating:
//    - pc_src    = pcs & cond_ex & en
//    - mem_write = mem_w & cond_ex & en
//    - reg_write = reg_w & ~no_write & cond_ex & en
//  - While reset is high: pc_src, reg_write and mem_write are forced 0; flags = RESET_FLAGS;
//    cond_ex is still evaluated.
//  - en=0: no flag update and all strobes 0; flags hold indefinitely.
//  - A failed condition blocks the flag update even with flag_w=2'b11 (e.g. CMPNE when Z=1).
//  - Reset asserted mid-cycle clears flags immediately, without waiting for clk; the first
//    edge after deassertion may update flags normally.
//  - X on flag_w or cond while en=0 must not corrupt the flags.
// STRUCTURE
//  - Shared package arm_pkg:
//    - cond_e enum (EQ..AL, NV=4'b1111)
//    - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//    - flag_w bit indices FW_NZ=1, FW_CV=0
//  - One combinational sub-module, cond_check (cond, flags -> cond_ex), reused by a later
//    pipelined core.
//  - The flags register and gating live in cond_unit.
// TESTING
//  1. reset=1 with reg_w=1, cond=AL -> reg_write=0, flags=0000; release reset -> reg_write=1.
//  2. cond=AL, flag_w=11, alu_flags=0100, en=1, edge -> flags=0100; then cond=EQ -> cond_ex=1;
//     cond=NE -> cond_ex=0.
//  3. flags=0100, cond=NE, flag_w=11, alu_flags=1010, reg_w=1 -> cond_ex=0, reg_write=0,
//     flags remain 0100 after the edge.
//  4. flags=0000, flag_w=10, alu_flags=1111 -> flags=1100 (C,V held);
//     then flag_w=01, alu_flags=0011 -> flags=1111.
//  5. Sweep all 16 cond x 16 flags against the reference table; cond=1111 -> cond_ex=0 always.
//  6. en=0, flag_w=11, alu_flags=1111 for 3 edges -> flags unchanged, all strobes 0;
//     assert reset between edges -> flags=RESET_FLAGS asynchronously.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM core definitions.
// Condition encodings and NZCV / flag-write bit positions.
package arm_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Condition-field evaluator.
// Pure combinational: cond + stored NZCV -> pass/fail.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition; NV and any unknown code never pass.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      EQ:      cond_ex = z;
      NE:      cond_ex = ~z;
      CS:      cond_ex = c;
      CC:      cond_ex = ~c;
      MI:      cond_ex = n;
      PL:      cond_ex = ~n;
      VS:      cond_ex = v;
      VC:      cond_ex = ~v;
      HI:      cond_ex = c & ~z;
      LS:      cond_ex = ~c | z;
      GE:      cond_ex = ~(n ^ v);
      LT:      cond_ex = n ^ v;
      GT:      cond_ex = ~z & ~(n ^ v);
      LE:      cond_ex = z | (n ^ v);
      AL:      cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// NZCV status register and write-strobe gating.
// Non-executed or stalled instructions leave no architectural trace.
module cond_unit
  import arm_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         HAS_STALL   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       cond_ex,
  output logic [3:0] flags
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       en_eff;
  logic       upd;
  logic       go;

  assign en_eff = HAS_STALL ? en : 1'b1;

  cond_check u_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // Only executed, non-stalled instructions may touch the flags.
  assign upd = en_eff & cond_ex;

  // Next-state flags: each pair loads only when its enable is set.
  always_comb begin
    flags_d = flags_q;
    if (upd && flag_w[FW_NZ]) begin
      flags_d[FLAG_N] = alu_flags[FLAG_N];
      flags_d[FLAG_Z] = alu_flags[FLAG_Z];
    end
    if (upd && flag_w[FW_CV]) begin
      flags_d[FLAG_C] = alu_flags[FLAG_C];
      flags_d[FLAG_V] = alu_flags[FLAG_V];
    end
  end

  // Flags register with immediate clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Strobes are dead during reset, stall or failed condition.
  assign go        = ~reset & en_eff & cond_ex;
  assign pc_src    = go & pcs;
  assign mem_write = go & mem_w;
  assign reg_write = go & reg_w & ~no_write;
  assign flags     = flags_q;

endmodule
